// File: rtl/layer7_argmax_if.sv
// Bus between the layer-7 score source / readback master and the argmax block.
// result_valid is a one-way strobe: the block accepts every valid sample and never back-pressures.
interface layer7_argmax_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic [15:0]      result_data;
    logic             result_valid;
    logic [IDX_W-1:0] rd_addr;
    logic [15:0]      rd_data;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] class_index;
    logic [15:0]      class_score;
    logic             err_extra;
    logic [1:0]       dbg_state;

    modport master (
        output start, result_data, result_valid, rd_addr,
        input  rd_data, busy, done, class_index, class_score, err_extra, dbg_state
    );

    modport slave (
        input  start, result_data, result_valid, rd_addr,
        output rd_data, busy, done, class_index, class_score, err_extra, dbg_state
    );
endinterface

// File: rtl/layer7_argmax.sv
// Collects NUM_CLASS signed Q6.10 scores per frame, tracks the running maximum
// (ties keep the lower index) and keeps every score in a readable buffer.
module layer7_argmax #(
    parameter int NUM_CLASS = 10,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    layer7_argmax_if.slave       bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      score_q, score_d;
    logic             err_q, err_d;
    logic             wr_en;
    logic [15:0]      rd_data_q;
    logic [15:0]      buf_q [NUM_CLASS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            score_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            score_q <= score_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        score_d = score_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        if (bus.start) begin
            // A simultaneous valid sample is dropped silently.
            state_d = ST_COLLECT;
            count_d = '0;
            idx_d   = '0;
            score_d = '0;
        end else if (bus.result_valid) begin
            if (state_q == ST_COLLECT) begin
                wr_en = 1'b1;
                if (count_q == '0 || $signed(bus.result_data) > $signed(score_q)) begin
                    idx_d   = count_q;
                    score_d = bus.result_data;
                end
                if (count_q == LAST_IDX) begin
                    count_d = '0;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // Score buffer is deliberately not reset; rst only blocks writes.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            buf_q[count_q] <= bus.result_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if ({1'b0, bus.rd_addr} < (IDX_W + 1)'(NUM_CLASS)) begin
            rd_data_q <= buf_q[bus.rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.busy        = (state_q == ST_COLLECT);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.class_index = idx_q;
    assign bus.class_score = score_q;
    assign bus.err_extra   = err_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_layer7_argmax.sv
// Randomized frames against a whole-frame argmax model; results checked via a scoreboard queue.
module tb_layer7_argmax;
    localparam int NC    = 10;
    localparam int IDX_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [IDX_W+15:0] exp_q [$];
    logic [IDX_W+15:0] last_exp;
    logic [15:0]       frame_s [NC];
    logic [15:0]       tb_mem  [NC];
    bit                mem_ok  [NC];
    logic              done_prev = 1'b0;

    layer7_argmax_if #(.IDX_W(IDX_W)) bus ();

    layer7_argmax #(.NUM_CLASS(NC), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first index holding the largest signed value.
    function automatic logic [IDX_W+15:0] ref_argmax();
        int best = 0;
        for (int i = 1; i < NC; i++)
            if ($signed(frame_s[i]) > $signed(frame_s[best])) best = i;
        return {IDX_W'(best), frame_s[best]};
    endfunction

    // Monitor: every rising done pops one expected result.
    always @(negedge clk) begin
        if (!rst && bus.done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                last_exp = exp_q.pop_front();
                check("class_index", 32'(bus.class_index), 32'(last_exp[IDX_W+15:16]));
                check("class_score", 32'(bus.class_score), 32'(last_exp[15:0]));
            end
        end
        done_prev <= bus.done;
    end

    task automatic do_start();
        bus.start = 1'b1;
        bus.result_valid = 1'b0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_frame(input int gap_max, input bit fixed_gap);
        int gap;
        exp_q.push_back(ref_argmax());
        for (int i = 0; i < NC; i++) begin
            bus.rd_addr      = IDX_W'(i);
            bus.result_data  = frame_s[i];
            bus.result_valid = 1'b1;
            tick();
            bus.result_valid = 1'b0;
            @(negedge clk);
            if (mem_ok[i]) check("rd_same_addr_old", 32'(bus.rd_data), 32'(tb_mem[i]));
            tb_mem[i] = frame_s[i];
            mem_ok[i] = 1'b1;
            if (i == NC - 2) begin
                check("busy_before_last", 32'(bus.busy), 32'd1);
                check("done_before_last", 32'(bus.done), 32'd0);
            end
            if (i == NC - 1) begin
                check("done_latency", 32'(bus.done), 32'd1);
                check("busy_after_last", 32'(bus.busy), 32'd0);
            end else begin
                gap = fixed_gap ? gap_max : $urandom_range(gap_max, 0);
                repeat (gap) begin
                    tick();
                    @(negedge clk);
                    check("busy_in_gap", 32'({bus.busy, bus.done}), 32'b10);
                end
            end
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.result_data  = '0;
        bus.result_valid = 1'b1;
        bus.rd_addr      = '0;
        for (int i = 0; i < NC; i++) mem_ok[i] = 1'b0;

        // Reset, with a stray valid that rst must override.
        repeat (2) tick();
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err_extra), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_class", 32'({bus.class_index, bus.class_score}), 32'd0);
        bus.result_valid = 1'b0;
        rst = 1'b0;

        // Tie keeps lower index.
        frame_s = '{16'h0100, 16'hFF00, 16'h0400, 16'h0200, 16'h0400, 0, 0, 0, 0, 0};
        do_start();
        run_frame(0, 1'b1);

        // All-negative ascending scores.
        for (int i = 0; i < NC; i++) frame_s[i] = 16'hF000 + 16'(i);
        do_start();
        run_frame(0, 1'b1);

        // Sparse valids, max at index 0.
        for (int i = 0; i < NC; i++) frame_s[i] = 16'(i * 100);
        frame_s[0] = 16'h7FFF;
        do_start();
        run_frame(3, 1'b1);

        // Aborted frame, then restart carried by a start+valid cycle.
        do_start();
        for (int i = 0; i < 4; i++) begin
            bus.result_data  = 16'($urandom);
            bus.result_valid = 1'b1;
            tick();
            tb_mem[i] = bus.result_data;
            mem_ok[i] = 1'b1;
        end
        bus.start        = 1'b1;
        bus.result_data  = 16'h7FFF;
        bus.result_valid = 1'b1;
        tick();
        bus.start        = 1'b0;
        bus.result_valid = 1'b0;
        for (int i = 0; i < NC; i++) frame_s[i] = 16'($urandom_range(16'h3FFF, 0));
        run_frame(0, 1'b1);
        check("abort_err_extra", 32'(bus.err_extra), 32'd0);

        // Random frames, including forced negative/positive extremes and duplicates.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NC; i++) frame_s[i] = 16'($urandom);
            if (f == 2) frame_s[$urandom_range(NC - 1, 0)] = 16'h8000;
            if (f == 3) begin
                frame_s[7] = 16'h7FFF;
                frame_s[3] = 16'h7FFF;
            end
            do_start();
            run_frame(2, 1'b0);
        end

        // Buffer readback.
        for (int i = 0; i < NC; i++) begin
            bus.rd_addr = IDX_W'(i);
            tick();
            @(negedge clk);
            check("rd_data", 32'(bus.rd_data), 32'(tb_mem[i]));
        end
        bus.rd_addr = IDX_W'(15);
        tick();
        @(negedge clk);
        check("rd_out_of_range", 32'(bus.rd_data), 32'd0);

        // Valid in DONE: flagged, results held.
        bus.result_data  = 16'h7FFF;
        bus.result_valid = 1'b1;
        tick();
        bus.result_valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("err_in_done", 32'(bus.err_extra), 32'd1);
        check("done_held", 32'(bus.done), 32'd1);
        check("index_held", 32'(bus.class_index), 32'(last_exp[IDX_W+15:16]));
        check("score_held", 32'(bus.class_score), 32'(last_exp[15:0]));

        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst2_state", 32'({bus.busy, bus.done, bus.err_extra}), 32'd0);
        check("rst2_class", 32'({bus.class_index, bus.class_score}), 32'd0);
        check("rst2_rd_data", 32'(bus.rd_data), 32'd0);
        rst = 1'b0;

        // rst mid-collection abandons the frame.
        do_start();
        for (int i = 0; i < 3; i++) begin
            bus.result_data  = 16'($urandom);
            bus.result_valid = 1'b1;
            tick();
            tb_mem[i] = bus.result_data;
        end
        bus.result_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_mid_state", 32'({bus.busy, bus.done}), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/layer7_argmax.md
LAYER7_ARGMAX -- requirements
Module: layer7_argmax

Interface
REQ-001 Parameter NUM_CLASS, default 10, number of final-layer output scores per frame (2..16).
REQ-002 Parameter IDX_W, default 4, width of the class index; SHALL satisfy 2**IDX_W >= NUM_CLASS.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port start  input  1  one-cycle pulse that begins a new frame.
REQ-006 Port result_data  input  16  signed Q6.10 biased score from the layer-7 systolic stage.
REQ-007 Port result_valid  input  1  result_data holds the next class score this cycle.
REQ-008 Port rd_addr  input  IDX_W  score-buffer read address.
REQ-009 Port rd_data  output  16  stored score at rd_addr, registered.
REQ-010 Port busy  output  1  high while collecting scores.
REQ-011 Port done  output  1  high while the frame result is final.
REQ-012 Port class_index  output  IDX_W  index of the maximum score.
REQ-013 Port class_score  output  16  maximum score value.
REQ-014 Port err_extra  output  1  sticky flag: a result_valid arrived outside collection.

Function
REQ-015 FSM states: IDLE, COLLECT, DONE; busy=1 only in COLLECT; done=1 only in DONE.
REQ-016 Any state: start=1 -> COLLECT next cycle; count, class_index and class_score cleared; score buffer not cleared.
REQ-017 In COLLECT, result_valid=1 and start=0: result_data written to buffer[count]; count incremented by 1.
REQ-018 Comparison is a signed 16-bit comparison; the first score of a frame is always taken as the running maximum.
REQ-019 A later score replaces the maximum only if it is strictly greater, so ties keep the lower index.
REQ-020 On the cycle the maximum is replaced, class_index<=count and class_score<=result_data.
REQ-021 Valid with count==NUM_CLASS-1 -> DONE next cycle; count wraps to 0.
REQ-022 Latency: done rises one cycle after the last valid; class_index and class_score are then final.
REQ-023 Valid cycles need not be contiguous; gaps hold all state in COLLECT.
REQ-024 In DONE, outputs stay stable until the next start or rst.
REQ-025 start and result_valid in the same cycle: start wins; the sample is discarded and not flagged.
REQ-026 start during COLLECT aborts the frame and restarts it per REQ-016.
REQ-027 result_valid=1 with start=0 in IDLE or DONE: sample ignored, err_extra<=1; err_extra clears only on rst.
REQ-028 rd_data<=buffer[rd_addr] every cycle (1-cycle read latency).
REQ-029 A write and a read to the same address in the same cycle return the old value.
REQ-030 rd_addr>=NUM_CLASS returns 16'h0000.

Reset
REQ-031 rst=1 at a clock edge -> state IDLE, count=0, class_index=0, class_score=16'h0000, err_extra=0, busy=0, done=0, rd_data=16'h0000.
REQ-032 Buffer contents are not reset; rst has priority over start and result_valid.
REQ-033 rst mid-COLLECT abandons the frame; done stays low until a new frame completes.

Verification
REQ-034 NUM_CLASS=10: start, then 10 contiguous valids with scores 0x0100,0xFF00,0x0400,0x0200,0x0400,0,0,0,0,0 -> done 1 cycle after the 10th valid; class_index=2, class_score=0x0400 (tie keeps index 2).
REQ-035 All scores negative, 0xF000..0xF009 ascending -> class_index=9, class_score=0xF009 (signed compare).
REQ-036 Valids with 3-cycle gaps, max 0x7FFF at index 0 -> busy held throughout; done after the 10th valid only; class_index=0.
REQ-037 start, 4 valids, start+valid in the same cycle, then 10 valids -> first frame discarded; result reflects only the last 10; err_extra=0.
REQ-038 Valid while in DONE -> err_extra=1; outputs unchanged; rst -> all REQ-031 values.
REQ-039 After a frame, read rd_addr 0..9 -> rd_data equals the written scores one cycle later; rd_addr=15 -> 0x0000.
